// File: rtl/pim_sched_pkg.sv
// rtl/pim_sched_pkg.sv - shared state/mode encodings and sizing helper for the PIM MAC scheduler
package pim_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COMP  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_COMP = 1'b1;

  // Bits needed to hold an occupancy value from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pim_res_fifo.sv
// rtl/pim_res_fifo.sv - result buffer between the array read pipe and the result stream
module pim_res_fifo
  import pim_sched_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int CW = cnt_width(DEPTH),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_tvalid,
  input  logic [WIDTH-1:0] push_tdata,
  output logic             pop_tvalid,
  input  logic             pop_tready,
  output logic [WIDTH-1:0] pop_tdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pop_tvalid = (count != '0);
  assign pop_ok     = pop_tvalid && pop_tready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts a push.
  assign push_ok    = push_tvalid && ((count != CW'(DEPTH)) || pop_ok);
  assign pop_tdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= bump(rd_ptr);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pim_mac_sched.sv
// rtl/pim_mac_sched.sv - sequences weight loads and credit-limited MAC reads for a PIM array
module pim_mac_sched
  import pim_sched_pkg::*;
#(
  parameter int INPUT_SIZE  = 256,
  parameter int ADDRS_WIDTH = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int RD_LAT      = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_mode,
  input  logic [ADDRS_WIDTH-1:0] cmd_base,
  input  logic [ADDRS_WIDTH:0]   cmd_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [INPUT_SIZE-1:0]  wr_data,
  input  logic [INPUT_SIZE-1:0]  vec_data,
  output logic                   pim_we,
  output logic [ADDRS_WIDTH-1:0] pim_addr,
  output logic [INPUT_SIZE-1:0]  pim_data,
  input  logic [OUT_WIDTH-1:0]   pim_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OUT_WIDTH-1:0]   res_data,
  output logic                   res_last,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [ADDRS_WIDTH:0] LEN_ONE = (ADDRS_WIDTH + 1)'(1);

  sched_state_t           state;
  logic [ADDRS_WIDTH-1:0] addr;
  logic [ADDRS_WIDTH:0]   remain;
  logic [INPUT_SIZE-1:0]  vec_q;
  logic                   done_q;
  logic [RD_LAT-1:0]      pipe_v;
  logic [RD_LAT-1:0]      pipe_last;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          inflight;
  logic [OUT_WIDTH:0]     fifo_head;
  logic                   fifo_valid;
  logic                   cmd_fire;
  logic                   wr_fire;
  logic                   pop_fire;
  logic                   last_pop;
  logic                   issue;
  logic                   issue_last;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign pop_fire = res_valid && res_ready;
  assign last_pop = pop_fire && fifo_head[OUT_WIDTH];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_v[i]);
    end
  end

  // A FIFO slot is reserved from issue until pop, so returning reads can never overrun it.
  assign issue      = (state == ST_COMP) && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
  assign issue_last = issue && (remain == LEN_ONE);

  assign pim_we    = wr_fire;
  assign pim_addr  = addr;
  assign pim_data  = (state == ST_LOAD) ? wr_data : vec_q;
  assign busy      = (state != ST_IDLE);
  assign res_valid = fifo_valid;
  assign res_data  = fifo_head[OUT_WIDTH-1:0];
  assign res_last  = fifo_valid && fifo_head[OUT_WIDTH];
  assign done      = done_q || last_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      addr      <= '0;
      remain    <= '0;
      vec_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            addr   <= cmd_base;
            remain <= cmd_len;
            if (cmd_mode == MODE_COMP) begin
              vec_q <= vec_data;
            end
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else if (cmd_mode == MODE_LOAD) begin
              state     <= ST_LOAD;
              cmd_ready <= 1'b0;
              wr_ready  <= 1'b1;
            end else begin
              state     <= ST_COMP;
              cmd_ready <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (wr_fire) begin
            addr   <= addr + ADDRS_WIDTH'(1);
            remain <= remain - LEN_ONE;
            if (remain == LEN_ONE) begin
              state     <= ST_IDLE;
              wr_ready  <= 1'b0;
              cmd_ready <= 1'b1;
              done_q    <= 1'b1;
            end
          end
        end
        ST_COMP: begin
          if (issue) begin
            addr   <= addr + ADDRS_WIDTH'(1);
            remain <= remain - LEN_ONE;
            if (issue_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      pipe_v[0]    <= issue;
      pipe_last[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  pim_res_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_tvalid (pipe_v[RD_LAT-1]),
    .push_tdata  ({pipe_last[RD_LAT-1], pim_out}),
    .pop_tvalid  (fifo_valid),
    .pop_tready  (res_ready),
    .pop_tdata   (fifo_head),
    .count       (fifo_count)
  );

endmodule

// File: tb/tb_pim_mac_sched.sv
// tb/tb_pim_mac_sched.sv - table-driven self-checking bench for pim_mac_sched
module tb_pim_mac_sched;
  import pim_sched_pkg::*;

  localparam int INPUT_SIZE  = 256;
  localparam int ADDRS_WIDTH = 8;
  localparam int OUT_WIDTH   = 8;
  localparam int RD_LAT      = 1;
  localparam int FIFO_DEPTH  = 4;

  typedef struct {
    logic       mode;
    logic [7:0] base;
    logic [8:0] len;
    int         stall;
    bit         toggle;
    int         done_off;
  } vec_t;

  logic                   clk;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_mode;
  logic [ADDRS_WIDTH-1:0] cmd_base;
  logic [ADDRS_WIDTH:0]   cmd_len;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [INPUT_SIZE-1:0]  wr_data;
  logic [INPUT_SIZE-1:0]  vec_data;
  logic                   pim_we;
  logic [ADDRS_WIDTH-1:0] pim_addr;
  logic [INPUT_SIZE-1:0]  pim_data;
  logic [OUT_WIDTH-1:0]   pim_out;
  logic                   res_valid;
  logic                   res_ready;
  logic [OUT_WIDTH-1:0]   res_data;
  logic                   res_last;
  logic                   busy;
  logic                   done;

  int checks;
  int errors;
  int cyc;
  int stab_bad;
  logic [7:0]   we_addr_q[$];
  logic [255:0] we_data_q[$];
  int           we_cyc_q[$];
  logic [7:0]   res_data_q[$];
  logic         res_last_q[$];
  int           res_cyc_q[$];
  int           done_cyc_q[$];
  logic [7:0]   tog_pat;
  vec_t         vt[10];

  pim_mac_sched #(
    .INPUT_SIZE  (INPUT_SIZE),
    .ADDRS_WIDTH (ADDRS_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .RD_LAT      (RD_LAT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .vec_data  (vec_data),
    .pim_we    (pim_we),
    .pim_addr  (pim_addr),
    .pim_data  (pim_data),
    .pim_out   (pim_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Array model: one-cycle read returning column address + 1.
  always @(posedge clk) pim_out <= pim_addr + 8'd1;

  initial begin : monitor
    bit         hold_v;
    logic [7:0] hold_d;
    logic       hold_l;
    hold_v   = 1'b0;
    stab_bad = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (pim_we) begin
          we_addr_q.push_back(pim_addr);
          we_data_q.push_back(pim_data);
          we_cyc_q.push_back(cyc);
        end
        if (res_valid && res_ready) begin
          res_data_q.push_back(res_data);
          res_last_q.push_back(res_last);
          res_cyc_q.push_back(cyc);
        end
        if (done) done_cyc_q.push_back(cyc);
        if (hold_v && (!res_valid || res_data !== hold_d || res_last !== hold_l)) stab_bad++;
        hold_v = res_valid && !res_ready;
        hold_d = res_data;
        hold_l = res_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] wpat(input int i);
    return {8{32'h5a00_0000 + 32'(i)}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t r, input int k);
    int acc, we0, res0, dn0, sb0, sent, n_exp, n_act, n_min, guard;
    logic [255:0] vec;
    logic [7:0]   e;
    vec  = wpat(1000 + k);
    we0  = we_addr_q.size();
    res0 = res_data_q.size();
    dn0  = done_cyc_q.size();
    sb0  = stab_bad;
    @(posedge clk); #1;
    res_ready = (r.stall == 0) && !r.toggle;
    wr_valid  = 1'b1;
    wr_data   = wpat(0);
    cmd_valid = 1'b1;
    cmd_mode  = r.mode;
    cmd_base  = r.base;
    cmd_len   = r.len;
    vec_data  = vec;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    chk($sformatf("v%0d_accept", k), acc >= 0, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    vec_data  = ~vec;
    if (acc < 0) begin
      wr_valid = 1'b0;
      return;
    end
    if (r.mode == MODE_LOAD) begin
      sent = 0;
      for (guard = 0; guard < 100 && sent < int'(r.len); guard++) begin
        @(negedge clk); #1;
        if (wr_ready) begin
          @(posedge clk); #1;
          sent++;
          wr_data = wpat(sent);
        end
      end
    end
    for (guard = 0; guard < 600; guard++) begin
      @(negedge clk); #1;
      if (r.mode == MODE_COMP && r.len != 0 && cyc == acc + 1) begin
        chk($sformatf("v%0d_vec_latched", k), pim_data, vec);
        chk($sformatf("v%0d_busy_flags", k), {busy, cmd_ready, wr_ready, pim_we}, 4'b1000);
      end
      if (r.stall > 0 && cyc == acc + r.stall) begin
        chk($sformatf("v%0d_stall_addr", k), pim_addr, r.base + 8'(FIFO_DEPTH));
      end
      if (done_cyc_q.size() > dn0) break;
      @(posedge clk); #1;
      if (r.stall > 0)   res_ready = (cyc > acc + r.stall);
      else if (r.toggle) res_ready = tog_pat[cyc % 8];
    end
    chk($sformatf("v%0d_done_seen", k), done_cyc_q.size() > dn0, 1'b1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wr_valid  = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    chk($sformatf("v%0d_done_count", k), done_cyc_q.size() - dn0, 1);
    if (done_cyc_q.size() > dn0 && r.done_off >= 0)
      chk($sformatf("v%0d_done_cycle", k), done_cyc_q[dn0] - acc, r.done_off);

    n_exp = (r.mode == MODE_LOAD) ? int'(r.len) : 0;
    n_act = we_addr_q.size() - we0;
    chk($sformatf("v%0d_we_count", k), n_act, n_exp);
    n_min = (n_act < n_exp) ? n_act : n_exp;
    for (int i = 0; i < n_min; i++) begin
      e = r.base + 8'(i);
      chk($sformatf("v%0d_we_addr%0d", k, i), we_addr_q[we0 + i], e);
      chk($sformatf("v%0d_we_data%0d", k, i), we_data_q[we0 + i], wpat(i));
      chk($sformatf("v%0d_we_cyc%0d", k, i), we_cyc_q[we0 + i] - acc, i + 1);
    end

    n_exp = (r.mode == MODE_COMP) ? int'(r.len) : 0;
    n_act = res_data_q.size() - res0;
    chk($sformatf("v%0d_res_count", k), n_act, n_exp);
    n_min = (n_act < n_exp) ? n_act : n_exp;
    for (int i = 0; i < n_min; i++) begin
      e = r.base + 8'(i) + 8'd1;
      chk($sformatf("v%0d_res_data%0d", k, i), res_data_q[res0 + i], e);
      chk($sformatf("v%0d_res_last%0d", k, i), res_last_q[res0 + i], i == n_exp - 1);
      if (r.stall == 0 && !r.toggle)
        chk($sformatf("v%0d_res_cyc%0d", k, i), res_cyc_q[res0 + i] - acc, i + 3);
    end
    if (n_exp > 0 && n_act == n_exp && done_cyc_q.size() > dn0)
      chk($sformatf("v%0d_done_on_last_pop", k), done_cyc_q[dn0], res_cyc_q[res0 + n_act - 1]);
    chk($sformatf("v%0d_res_stable", k), stab_bad - sb0, 0);
  endtask

  initial begin : main
    int acc;
    checks    = 0;
    errors    = 0;
    tog_pat   = 8'b1011_0010;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    vec_data  = '0;
    res_ready = 1'b0;

    vt[0] = '{MODE_LOAD, 8'd4,   9'd3,   0,  1'b0, 4};
    vt[1] = '{MODE_COMP, 8'd0,   9'd8,   0,  1'b0, 10};
    vt[2] = '{MODE_COMP, 8'd0,   9'd16,  10, 1'b0, -1};
    vt[3] = '{MODE_COMP, 8'd255, 9'd3,   0,  1'b0, 5};
    vt[4] = '{MODE_LOAD, 8'd9,   9'd0,   0,  1'b0, 1};
    vt[5] = '{MODE_COMP, 8'd7,   9'd0,   0,  1'b0, 1};
    vt[6] = '{MODE_LOAD, 8'd254, 9'd4,   0,  1'b0, 5};
    vt[7] = '{MODE_COMP, 8'd250, 9'd9,   0,  1'b1, -1};
    vt[8] = '{MODE_COMP, 8'd0,   9'd256, 0,  1'b0, 258};
    vt[9] = '{MODE_COMP, 8'd100, 9'd2,   0,  1'b0, 4};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", {cmd_ready, wr_ready, pim_we, res_valid, res_last, busy, done}, 7'b0);
    chk("rst_addr", pim_addr, 8'd0);
    chk("rst_data", pim_data, 256'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_release_cmd_ready", {cmd_ready, busy}, 2'b10);

    for (int k = 0; k < 9; k++) run_vec(vt[k], k);

    // Reset while two results sit in the buffer with the consumer stalled.
    @(posedge clk); #1;
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = MODE_COMP;
    cmd_base  = 8'd0;
    cmd_len   = 9'd8;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    chk("mid_rst_accept", acc >= 0, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && cyc < acc + 4; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_rst_buffered", {res_valid, res_data}, {1'b1, 8'd1});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", {res_valid, res_last, busy, done, cmd_ready, wr_ready, pim_we}, 7'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_release", {cmd_ready, busy, res_valid}, 3'b100);

    run_vec(vt[9], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
